// File: rtl/line_binarize_pack_pkg.sv
// line_binarize_pack_pkg
// Shared definitions for the row binariser/packer.
//   WE / HE            default row width and frame height
//   THRESHOLD_DEFAULT  default binarisation level
//   PIX_BLACK/WHITE    bit polarity of a packed pixel
//   state_t            row-assembly state machine encoding
package line_binarize_pack_pkg;

    localparam int WE                = 180;
    localparam int HE                = 240;
    localparam int THRESHOLD_DEFAULT = 128;

    localparam logic PIX_BLACK = 1'b0;
    localparam logic PIX_WHITE = 1'b1;

    typedef enum logic [1:0] {
        WAIT_FRAME,
        ACCUM,
        DISCARD,
        DONE
    } state_t;

endpackage

// File: rtl/line_binarize_pack_holdoff_timer.sv
// line_holdoff_timer
// Load/decrement counter that spaces row publications.
//   i_clk   clock
//   i_rst   synchronous active-high reset (counter -> 0)
//   i_load  load HOLD (asserted in the publish cycle)
//   o_zero  publishing is allowed this cycle
module line_holdoff_timer #(
    parameter int HOLD = 182
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    output logic o_zero
);
    localparam int CNT_W = $clog2(HOLD + 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= CNT_W'(HOLD);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Open one count early: the publish itself is a registered edge, so a
    // count of 1 here places the next pulse exactly HOLD cycles after the last.
    assign o_zero = (r_cnt <= CNT_W'(1));

endmodule

// File: rtl/line_binarize_pack.sv
// line_binarize_pack
// Binarises a grayscale pixel stream, packs each row into a we-bit word and
// publishes (line1 = current row, line2 = previous row, h = row index) with a
// one-cycle line_clk strobe, spaced at least HOLD cycles apart.
// Optional feature macro: LINE_MAJ3_EN (3-tap horizontal majority filter on
// the row as it enters the pending slot).
//   video_clk  clock              rst        sync active-high reset
//   vsync      frame-start pulse  pix_valid  pixel qualifier
//   pix_eol    last pixel of line pix_data   grayscale pixel
//   line_clk   publish strobe     line1/2    current/previous row, bit c = col c
//   h          row index of line1 ovf        sticky row-dropped flag
module line_binarize_pack
    import line_binarize_pack_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int we         = WE,
    parameter int he         = HE,
    parameter int THRESHOLD  = THRESHOLD_DEFAULT,
    parameter int HOLD       = we + 2
) (
    input  logic                  video_clk,
    input  logic                  rst,
    input  logic                  vsync,
    input  logic                  pix_valid,
    input  logic                  pix_eol,
    input  logic [DATA_WIDTH-1:0] pix_data,
    output logic                  line_clk,
    output logic [we-1:0]         line1,
    output logic [we-1:0]         line2,
    output logic [DATA_WIDTH-1:0] h,
    output logic                  ovf
);
    localparam int                  COL_W = $clog2(we);
    localparam logic [DATA_WIDTH-1:0] THR = DATA_WIDTH'(THRESHOLD);

    state_t                r_state;
    logic [COL_W-1:0]      r_col;
    logic [DATA_WIDTH-1:0] r_row;
    logic [we-1:0]         r_asm;

    logic                  r_cmp_vld_p1;
    logic [we-1:0]         r_cmp_row_p1;
    logic [DATA_WIDTH-1:0] r_cmp_idx_p1;

    logic                  r_pend;
    logic [we-1:0]         r_pend_row;
    logic [DATA_WIDTH-1:0] r_pend_idx;

    logic                  w_bit;
    logic                  w_last_col;
    logic [we-1:0]         w_row_ins;
    logic [we-1:0]         w_filt;
    logic                  w_zero;
    logic                  w_publish;

    function automatic logic [we-1:0] maj3_row(input logic [we-1:0] row);
        logic [we+1:0] ext;
        logic [we-1:0] res;
        // Edge columns see a copy of themselves beyond the border.
        ext = {row[we-1], row, row[0]};
        for (int c = 0; c < we; c++) begin
            res[c] = (ext[c] & ext[c+1]) | (ext[c] & ext[c+2]) | (ext[c+1] & ext[c+2]);
        end
        return res;
    endfunction

    assign w_bit      = (pix_data >= THR);
    assign w_last_col = (r_col == COL_W'(we - 1));

    always_comb begin
        w_row_ins        = r_asm;
        w_row_ins[r_col] = w_bit;
    end

`ifdef LINE_MAJ3_EN
    assign w_filt = maj3_row(r_cmp_row_p1);
`else
    assign w_filt = r_cmp_row_p1;
`endif

    // vsync cancels a publish that would otherwise land in the same cycle.
    assign w_publish = r_pend && w_zero && !vsync;

    line_holdoff_timer #(
        .HOLD (HOLD)
    ) u_holdoff (
        .i_clk  (video_clk),
        .i_rst  (rst),
        .i_load (w_publish),
        .o_zero (w_zero)
    );

    // Stage p0 -> p1: row assembly; a completed row is captured with its index.
    always_ff @(posedge video_clk) begin
        if (rst) begin
            r_state      <= WAIT_FRAME;
            r_col        <= '0;
            r_row        <= '0;
            r_cmp_vld_p1 <= 1'b0;
        end else if (vsync) begin
            r_state      <= ACCUM;
            r_col        <= '0;
            r_row        <= '0;
            r_asm        <= {we{PIX_WHITE}};
            r_cmp_vld_p1 <= 1'b0;
        end else begin
            r_cmp_vld_p1 <= 1'b0;
            case (r_state)
                ACCUM: begin
                    if (pix_valid) begin
                        if (pix_eol || w_last_col) begin
                            r_cmp_vld_p1 <= 1'b1;
                            r_cmp_row_p1 <= w_row_ins;
                            r_cmp_idx_p1 <= r_row;
                            r_col        <= '0;
                            r_asm        <= {we{PIX_WHITE}};
                            r_row        <= r_row + 1'b1;
                            if (r_row == DATA_WIDTH'(he - 1)) begin
                                r_state <= DONE;
                            end else if (!pix_eol) begin
                                // Row filled before eol: skip the overhang.
                                r_state <= DISCARD;
                            end
                        end else begin
                            r_asm <= w_row_ins;
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                DISCARD: begin
                    if (pix_valid && pix_eol) begin
                        r_state <= ACCUM;
                    end
                end
                default: ;
            endcase
        end
    end

    // Stage p1 -> p2: pending slot and publish registers.
    always_ff @(posedge video_clk) begin
        if (rst) begin
            line_clk <= 1'b0;
            line1    <= {we{PIX_WHITE}};
            line2    <= {we{PIX_WHITE}};
            h        <= '0;
            ovf      <= 1'b0;
            r_pend   <= 1'b0;
        end else begin
            line_clk <= w_publish;
            if (vsync) begin
                r_pend <= 1'b0;
                ovf    <= 1'b0;
            end else begin
                if (w_publish) begin
                    line2 <= (r_pend_idx == '0) ? {we{PIX_WHITE}} : line1;
                    line1 <= r_pend_row;
                    h     <= r_pend_idx;
                end
                if (r_cmp_vld_p1) begin
                    // A slot being published this cycle is free for the new row.
                    if (r_pend && !w_publish) begin
                        ovf <= 1'b1;
                    end else begin
                        r_pend     <= 1'b1;
                        r_pend_row <= w_filt;
                        r_pend_idx <= r_cmp_idx_p1;
                    end
                end else if (w_publish) begin
                    r_pend <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_line_binarize_pack.sv
module tb_line_binarize_pack;
    localparam int W    = 180;
    localparam int HN   = 240;
    localparam int HOLD = 182;
    localparam int THR  = 128;

    logic          clk = 1'b0;
    logic          rst = 1'b0, vsync = 1'b0, pix_valid = 1'b0, pix_eol = 1'b0;
    logic [7:0]    pix_data = 8'd0;
    logic          line_clk;
    logic [W-1:0]  line1, line2;
    logic [7:0]    h;
    logic          ovf;

    always #5 clk = ~clk;

    line_binarize_pack #(.DATA_WIDTH(8), .we(W), .he(HN), .THRESHOLD(THR), .HOLD(HOLD)) dut (
        .video_clk(clk), .rst(rst), .vsync(vsync), .pix_valid(pix_valid),
        .pix_eol(pix_eol), .pix_data(pix_data), .line_clk(line_clk),
        .line1(line1), .line2(line2), .h(h), .ovf(ovf));

    typedef struct { logic [W-1:0] l1; logic [W-1:0] l2; int hv; int t; } pub_t;
    pub_t exp_q[$];
    pub_t obs_q[$];

    int n_tests = 0, n_fail = 0;
    int cyc = 0;
    logic rst_q = 1'b0;
    logic prev_clk = 1'b0;
    logic [W+7:0] prev_out;
    int stab_err = 0, width_err = 0;
    logic [W-1:0] ONES = '1;
    logic [7:0] pbuf [0:255];

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    // Publish log plus stability / pulse-width watch, sampled mid-cycle.
    always @(negedge clk) begin
        if (line_clk === 1'b1) obs_q.push_back('{line1, line2, int'(h), cyc});
        else if (!rst_q && ({line1, line2[7:0]} !== prev_out)) stab_err++;
        if (line_clk === 1'b1 && prev_clk === 1'b1) width_err++;
        prev_clk <= line_clk;
        prev_out <= {line1, line2[7:0]};
    end

    // ---------------- reference model ----------------
    int           m_mode;      // 0 wait frame, 1 accumulate, 2 discard, 3 done
    logic [W-1:0] m_bits;
    int           m_col, m_row;
    logic         m_ovf = 1'b0;
    logic         m_pend = 1'b0;
    logic [W-1:0] m_pend_row;
    int           m_pend_idx, m_pend_pt;
    int           m_last_pub = -100000;
    logic [W-1:0] m_line1 = '1;

    function automatic logic [W-1:0] filt(input logic [W-1:0] r);
`ifdef LINE_MAJ3_EN
        logic [W-1:0] o;
        for (int c = 0; c < W; c++) begin
            int lft, mid, rgt;
            mid = int'(r[c]);
            if (c == 0) lft = int'(r[0]); else lft = int'(r[c-1]);
            if (c == W-1) rgt = int'(r[W-1]); else rgt = int'(r[c+1]);
            o[c] = ((lft + mid + rgt) >= 2);
        end
        return o;
`else
        return r;
`endif
    endfunction

    task automatic m_publish_due(input int t);
        logic [W-1:0] l2;
        if (m_pend && m_pend_pt <= t) begin
            l2 = (m_pend_idx == 0) ? ONES : m_line1;
            exp_q.push_back('{m_pend_row, l2, m_pend_idx, m_pend_pt});
            m_line1    = m_pend_row;
            m_last_pub = m_pend_pt;
            m_pend     = 1'b0;
        end
    endtask

    // Row completed by the pixel sampled at edge c; it reaches the slot at c+1.
    task automatic m_complete(input logic [W-1:0] row, input int idx, input int c);
        m_publish_due(c + 1);
        if (m_pend) m_ovf = 1'b1;
        else begin
            m_pend     = 1'b1;
            m_pend_row = filt(row);
            m_pend_idx = idx;
            m_pend_pt  = (c + 2 > m_last_pub + HOLD) ? c + 2 : m_last_pub + HOLD;
        end
    endtask

    task automatic step(input logic r, input logic vs, input logic v, input logic [7:0] d, input logic e);
        int c;
        c = cyc + 1;
        rst = r; vsync = vs; pix_valid = v; pix_data = d; pix_eol = e;
        if (r) begin
            m_publish_due(c - 1);
            m_mode = 0; m_ovf = 1'b0; m_pend = 1'b0;
            m_last_pub = -100000; m_line1 = ONES;
        end else if (vs) begin
            m_publish_due(c - 1);
            m_pend = 1'b0; m_mode = 1; m_bits = ONES;
            m_col = 0; m_row = 0; m_ovf = 1'b0;
        end else if (v) begin
            if (m_mode == 1) begin
                m_bits[m_col] = (int'(d) >= THR);
                if (e || m_col == W-1) begin
                    m_complete(m_bits, m_row, c);
                    m_bits = ONES; m_col = 0; m_row++;
                    if (m_row == HN) m_mode = 3;
                    else if (!e) m_mode = 2;
                end else m_col++;
            end else if (m_mode == 2 && e) m_mode = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    endtask

    task automatic send_row(input int n, input logic eol_last);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, pbuf[i], eol_last && (i == n-1));
    endtask

    function automatic logic [7:0] rpix();
        case ($urandom_range(0, 3))
            0: return 8'd127;
            1: return 8'd128;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) pbuf[i] = rpix();
    endtask

    task automatic settle(input int n);
        idle(n);
        m_publish_due(cyc - 1);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) step(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
        n_tests++; if (line_clk !== 1'b0) begin n_fail++; $display("FAIL reset_line_clk got %b want 0", line_clk); end
        n_tests++; if (line1 !== ONES) begin n_fail++; $display("FAIL reset_line1 got %h want all ones", line1); end
        n_tests++; if (line2 !== ONES) begin n_fail++; $display("FAIL reset_line2 got %h want all ones", line2); end
        n_tests++; if (h !== 8'd0) begin n_fail++; $display("FAIL reset_h got %0d want 0", h); end
        n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", ovf); end
        settle(5);
        n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL reset_no_pulse got %0d pulses want 0", obs_q.size()); end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_row0();
        int t_last;
        step(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
        for (int i = 0; i < W; i++) pbuf[i] = (i < 90) ? 8'd200 : 8'd10;
        send_row(W, 1'b1);
        t_last = cyc;
        settle(6);
        n_tests++; if (obs_q.size() != 1) begin n_fail++; $display("FAIL row0_count got %0d want 1", obs_q.size()); end
        else begin
            n_tests++; if (obs_q[0].t != t_last + 2) begin n_fail++; $display("FAIL row0_latency got %0d want %0d", obs_q[0].t, t_last + 2); end
            n_tests++; if (obs_q[0].hv != 0) begin n_fail++; $display("FAIL row0_h got %0d want 0", obs_q[0].hv); end
            n_tests++; if (obs_q[0].l1 !== {{90{1'b0}}, {90{1'b1}}}) begin n_fail++; $display("FAIL row0_line1 got %h", obs_q[0].l1); end
            n_tests++; if (obs_q[0].l2 !== ONES) begin n_fail++; $display("FAIL row0_line2 got %h want all ones", obs_q[0].l2); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back();
        idle(200);
        step(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
        fill_random(W); send_row(W, 1'b1);
        fill_random(W); send_row(W, 1'b1);
        settle(400);
        n_tests++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_tests++;
            if ({obs_q[i].l1, obs_q[i].l2, obs_q[i].hv, obs_q[i].t} !== {exp_q[i].l1, exp_q[i].l2, exp_q[i].hv, exp_q[i].t}) begin
                n_fail++; $display("FAIL b2b_pub%0d got h=%0d t=%0d l1=%h want h=%0d t=%0d l1=%h", i, obs_q[i].hv, obs_q[i].t, obs_q[i].l1, exp_q[i].hv, exp_q[i].t, exp_q[i].l1);
            end
        end
        if (obs_q.size() == 2) begin
            n_tests++; if (obs_q[1].t - obs_q[0].t != HOLD) begin n_fail++; $display("FAIL b2b_spacing got %0d want %0d", obs_q[1].t - obs_q[0].t, HOLD); end
        end
        n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL b2b_ovf got %b want 0", ovf); end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_overflow();
        idle(200);
        step(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
        repeat (3) begin fill_random(20); send_row(20, 1'b1); end
        settle(400);
        n_tests++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL ovf_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_tests++;
            if ({obs_q[i].l1, obs_q[i].l2, obs_q[i].hv, obs_q[i].t} !== {exp_q[i].l1, exp_q[i].l2, exp_q[i].hv, exp_q[i].t}) begin
                n_fail++; $display("FAIL ovf_pub%0d got h=%0d t=%0d l1=%h want h=%0d t=%0d l1=%h", i, obs_q[i].hv, obs_q[i].t, obs_q[i].l1, exp_q[i].hv, exp_q[i].t, exp_q[i].l1);
            end
        end
        n_tests++; if (obs_q.size() != 2 || obs_q[0].hv != 0 || obs_q[1].hv != 1) begin n_fail++; $display("FAIL ovf_h_seq got %0d pulses want h sequence 0,1", obs_q.size()); end
        n_tests++; if (ovf !== m_ovf || ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b want 1", ovf); end
        step(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
        n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b want 0", ovf); end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_short_long();
        idle(200);
        step(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
        for (int i = 0; i < 100; i++) pbuf[i] = 8'd0;
        send_row(100, 1'b1);
        idle(200);
        fill_random(200); send_row(200, 1'b1);
        settle(200);
        n_tests++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL shortlong_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_tests++;
            if ({obs_q[i].l1, obs_q[i].l2, obs_q[i].hv, obs_q[i].t} !== {exp_q[i].l1, exp_q[i].l2, exp_q[i].hv, exp_q[i].t}) begin
                n_fail++; $display("FAIL shortlong_pub%0d got h=%0d t=%0d l1=%h want h=%0d t=%0d l1=%h", i, obs_q[i].hv, obs_q[i].t, obs_q[i].l1, exp_q[i].hv, exp_q[i].t, exp_q[i].l1);
            end
        end
        if (obs_q.size() >= 1) begin
            n_tests++; if (obs_q[0].l1 !== {{80{1'b1}}, {100{1'b0}}}) begin n_fail++; $display("FAIL short_row_bits got %h", obs_q[0].l1); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_full_frame();
        idle(200);
        step(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
        for (int r = 0; r < HN + 2; r++) begin
            fill_random(W); send_row(W, 1'b1); idle(2);
        end
        settle(400);
        n_tests++; if (obs_q.size() != HN) begin n_fail++; $display("FAIL frame_count got %0d want %0d", obs_q.size(), HN); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_tests++;
            if ({obs_q[i].l1, obs_q[i].l2, obs_q[i].hv, obs_q[i].t} !== {exp_q[i].l1, exp_q[i].l2, exp_q[i].hv, exp_q[i].t}) begin
                n_fail++; $display("FAIL frame_pub%0d got h=%0d t=%0d l1=%h want h=%0d t=%0d l1=%h", i, obs_q[i].hv, obs_q[i].t, obs_q[i].l1, exp_q[i].hv, exp_q[i].t, exp_q[i].l1);
            end
        end
        if (obs_q.size() > 0) begin
            n_tests++; if (obs_q[obs_q.size()-1].hv != HN - 1) begin n_fail++; $display("FAIL frame_last_h got %0d want %0d", obs_q[obs_q.size()-1].hv, HN - 1); end
        end
        obs_q.delete(); exp_q.delete();
        step(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
        fill_random(W); send_row(W, 1'b1);
        settle(10);
        n_tests++; if (obs_q.size() != 1 || obs_q[0].hv != 0 || obs_q[0].l1 !== exp_q[0].l1 || obs_q[0].l2 !== ONES) begin
            n_fail++; $display("FAIL frame_restart got %0d pulses, want one pulse with h=0", obs_q.size());
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_maj3();
        logic want50;
        idle(200);
        step(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
        for (int i = 0; i < W; i++) pbuf[i] = (i == 50) ? 8'd0 : 8'd255;
        send_row(W, 1'b1);
        settle(6);
`ifdef LINE_MAJ3_EN
        want50 = 1'b1;
`else
        want50 = 1'b0;
`endif
        n_tests++; if (obs_q.size() != 1) begin n_fail++; $display("FAIL maj3_count got %0d want 1", obs_q.size()); end
        else begin
            n_tests++; if (obs_q[0].l1[50] !== want50) begin n_fail++; $display("FAIL maj3_col50 got %b want %b", obs_q[0].l1[50], want50); end
            n_tests++; if (obs_q[0].l1 !== exp_q[0].l1) begin n_fail++; $display("FAIL maj3_row got %h want %h", obs_q[0].l1, exp_q[0].l1); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid();
        int t_last;
        idle(200);
        step(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
        fill_random(20); send_row(20, 1'b1);
        idle(10);
        fill_random(10); send_row(10, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
        n_tests++; if ({line_clk, ovf, h} !== 10'd0 || line1 !== ONES || line2 !== ONES) begin
            n_fail++; $display("FAIL midreset_outputs got clk=%b ovf=%b h=%0d l1=%h", line_clk, ovf, h, line1);
        end
        step(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
        fill_random(20); send_row(20, 1'b1);
        t_last = cyc;
        settle(6);
        n_tests++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL midreset_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_tests++;
            if ({obs_q[i].l1, obs_q[i].l2, obs_q[i].hv, obs_q[i].t} !== {exp_q[i].l1, exp_q[i].l2, exp_q[i].hv, exp_q[i].t}) begin
                n_fail++; $display("FAIL midreset_pub%0d got h=%0d t=%0d want h=%0d t=%0d", i, obs_q[i].hv, obs_q[i].t, exp_q[i].hv, exp_q[i].t);
            end
        end
        if (obs_q.size() == 2) begin
            n_tests++; if (obs_q[1].t != t_last + 2) begin n_fail++; $display("FAIL midreset_holdoff got %0d want %0d", obs_q[1].t, t_last + 2); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_vsync_pixel();
        idle(200);
        step(1'b0, 1'b1, 1'b1, 8'd0, 1'b1);
        for (int i = 0; i < 30; i++) pbuf[i] = 8'd255;
        send_row(30, 1'b1);
        settle(6);
        n_tests++; if (obs_q.size() != 1 || exp_q.size() != 1) begin n_fail++; $display("FAIL vsyncpix_count got %0d want 1", obs_q.size()); end
        else begin
            n_tests++; if (obs_q[0].hv != 0 || obs_q[0].l1 !== ONES || obs_q[0].t != exp_q[0].t) begin
                n_fail++; $display("FAIL vsyncpix_row got h=%0d t=%0d l1=%h want h=0 t=%0d all ones", obs_q[0].hv, obs_q[0].t, obs_q[0].l1, exp_q[0].t);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_stability();
        n_tests++; if (stab_err != 0) begin n_fail++; $display("FAIL stability got %0d changes outside line_clk want 0", stab_err); end
        n_tests++; if (width_err != 0) begin n_fail++; $display("FAIL pulse_width got %0d wide pulses want 0", width_err); end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_row0();
        test_back_to_back();
        test_overflow();
        test_short_long();
        test_maj3();
        test_vsync_pixel();
        test_reset_mid();
        test_full_frame();
        test_stability();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
